dcache_miss_controller: RTL and testbench
=========================================

Name: dcache_miss_controller

Overview:
- Sequencing FSM for the 2-way, 8-set, 2-word-block write-back data cache.
- On a lookup miss, picks a victim way and writes it back to memory if it is valid and dirty. It then fetches the missing block word by word and commits the new line (v=1, dirty=0, tag, MRU) into the frame array.
- Sits between the dcache hit/frame-array logic and the memory-side ramstate_t handshake.
- Hit path and array storage live outside this block.

Parameters:
- WAYS, 2, ways per set; victim select is 1 bit.
- WORDS, 2, words per block.
- DTAG_W, 26, tag width.
- DIDX_W, 3, set index width.
- DBLK_W, 1, block-offset width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous active-high reset.
- miss  in  1  lookup missed; held high until miss_done.
- miss_addr  in  32  missing address, laid out as {tag, idx, blkoff, 2'b00}.
- way_v  in  WAYS  valid bits of set arr_idx.
- way_dirty  in  WAYS  dirty bits of set arr_idx.
- way_tag  in  WAYS*DTAG_W  tags of set arr_idx; way 0 in the LSBs.
- mru  in  1  most-recently-used way of set arr_idx.
- victim_word  in  32  array data at (arr_idx, arr_way, arr_word).
- arr_idx  out  DIDX_W  array set select.
- arr_way  out  1  array way select.
- arr_word  out  DBLK_W  array word select.
- fill_we  out  1  write fill_data to (arr_idx, arr_way, arr_word).
- fill_data  out  32  fetched word.
- fill_commit  out  1  pulse: set v=1, dirty=0, tag=latched tag, mru=arr_way.
- clean_we  out  1  pulse: clear dirty of (arr_idx, arr_way); used only by flush.
- mem_ren  out  1  memory read request.
- mem_wen  out  1  memory write request.
- mem_addr  out  32  memory word address.
- mem_store  out  32  write data.
- mem_load  in  32  read data; valid when ramstate==ACCESS.
- ramstate  in  2  ramstate_t; ACCESS = request completes this cycle.
- miss_done  out  1  one-cycle pulse; miss serviced.
- busy  out  1  FSM not in IDLE.
- flush  in  1  flush request (optional feature).
- flushed  out  1  flush complete (optional feature).

Behaviour:
- Reset: state=IDLE, word counter=0. All outputs 0, including arr_idx/arr_way/arr_word, mem_addr and mem_store.
- States: IDLE, WB, FILL, COMMIT, DONE, plus FLUSH_SCAN/FLUSH_WB when the optional feature is compiled in.
- IDLE:
  - arr_idx = miss_addr idx field (combinational).
  - On miss=1, latch tag and idx.
  - Victim = lowest-numbered invalid way; if both ways are valid, victim = ~mru.
  - Latch victim way, its dirty bit and its tag; clear the word counter.
  - Next state: WB if the victim is valid and dirty, else FILL.
- WB:
  - Outputs: mem_wen=1, mem_addr={victim_tag, idx, cnt, 2'b00}, mem_store=victim_word, arr_way=victim, arr_word=cnt.
  - On ACCESS: cnt++. After word WORDS-1: cnt=0, go to FILL.
- FILL:
  - Outputs: mem_ren=1, mem_addr={miss_tag, idx, cnt, 2'b00}, arr_way=victim, arr_word=cnt.
  - On ACCESS: fill_we=1 and fill_data=mem_load in the same cycle (combinational), then cnt++. After the last word, go to COMMIT.
- COMMIT: fill_commit=1 for one cycle, then DONE.
- DONE: miss_done=1 for one cycle, then IDLE. The requester must drop miss in the cycle after miss_done; a miss still high in IDLE starts a new service.
- ramstate handling:
  - FREE or BUSY: hold the request and all outputs stable.
  - ERROR: hold the request and retry; the counter does not advance.
- Latency for a clean miss with single-cycle memory: miss sampled at cycle 0, FILL in cycles 1–2, COMMIT in cycle 3, miss_done in cycle 4.
- A dirty victim adds WORDS cycles.
- mem_ren and mem_wen are never asserted together.
- The counter wraps only on the state transition, never mid-block.
- Inputs way_*, mru and miss_addr are ignored outside IDLE; all service values come from the latched copies.
- RST asserted mid-service returns to IDLE in the next cycle, with all requests deasserted and no commit. The array line may contain partial fill data but remains invalid only if the outer logic cleared v on miss; that clear is the outer logic's responsibility.

Optional Feature:
- Macro: DCACHE_FLUSH_EN.
- With the macro:
  - flush=1 in IDLE with miss=0 enters FLUSH_SCAN. miss takes priority if both are high in the same cycle.
  - FLUSH_SCAN walks (idx 0..7, way 0..1) one entry per cycle. A valid and dirty entry goes to FLUSH_WB.
  - FLUSH_WB writes back WORDS words using the WB addressing, pulses clean_we, then resumes the scan.
  - After (7,1), flushed=1 and is held until RST. The FSM stays in a terminal FLUSHED state; miss is ignored there.
- Without the macro: flush is ignored, flushed and clean_we are tied 0, and the FLUSH states do not exist.

Test Plan:
- Clean miss, empty set: way_v=00, miss_addr=0x0000_1048, 1-cycle memory -> reads 0x1048 then 0x104C; fill_we with arr_way=0; fill_commit in cycle 3; miss_done in cycle 4; no mem_wen.
- Dirty victim: way_v=11, mru=0, way1 dirty, tag1=0x155, miss idx=2 -> writes to {0x155,2,0,00} and {0x155,2,1,00} using victim_word, then fills into way 1.
- Memory stall/error: ramstate BUSY for 3 cycles, then ERROR, then ACCESS on the FILL word 0 read -> mem_addr and mem_ren are stable throughout; one fill_we only; miss_done delayed by 4 cycles.
- Reset mid-WB: RST after the first WB word -> IDLE next cycle; all outputs 0; no fill_commit and no miss_done.
- Back-to-back misses: miss held 1 cycle after miss_done with a new address -> second service starts with correctly re-latched tag and idx.
- DCACHE_FLUSH_EN: sets 0 and 5 way 1 dirty, flush=1 -> exactly 4 memory writes, 2 clean_we pulses, then flushed=1 and held.

Source files
------------

// File: rtl/dcache_miss_controller_if.sv
// Array-side and memory-side signal bundle for the dcache miss controller.
// master: the controller; slave: hit/array logic plus the memory port.
interface dcache_miss_controller_if #(
  parameter int WAYS   = 2,
  parameter int DTAG_W = 26,
  parameter int DIDX_W = 3,
  parameter int DBLK_W = 1
);
  logic                   miss;
  logic [31:0]            miss_addr;
  logic [WAYS-1:0]        way_v;
  logic [WAYS-1:0]        way_dirty;
  logic [WAYS*DTAG_W-1:0] way_tag;
  logic                   mru;
  logic [31:0]            victim_word;
  logic [DIDX_W-1:0]      arr_idx;
  logic                   arr_way;
  logic [DBLK_W-1:0]      arr_word;
  logic                   fill_we;
  logic [31:0]            fill_data;
  logic                   fill_commit;
  logic                   clean_we;
  logic                   mem_ren;
  logic                   mem_wen;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_store;
  logic [31:0]            mem_load;
  logic [1:0]             ramstate;
  logic                   miss_done;
  logic                   busy;
  logic                   flush;
  logic                   flushed;

  modport master (
    input  miss, miss_addr, way_v, way_dirty, way_tag, mru,
    input  victim_word, mem_load, ramstate, flush,
    output arr_idx, arr_way, arr_word, fill_we, fill_data,
    output fill_commit, clean_we, mem_ren, mem_wen,
    output mem_addr, mem_store, miss_done, busy, flushed
  );

  modport slave (
    output miss, miss_addr, way_v, way_dirty, way_tag, mru,
    output victim_word, mem_load, ramstate, flush,
    input  arr_idx, arr_way, arr_word, fill_we, fill_data,
    input  fill_commit, clean_we, mem_ren, mem_wen,
    input  mem_addr, mem_store, miss_done, busy, flushed
  );
endinterface

// File: rtl/dcache_miss_controller.sv
// Miss sequencer for the 2-way write-back dcache: victim write-back, fill, commit.
// Optional whole-cache flush is compiled in with DCACHE_FLUSH_EN.
module dcache_miss_controller #(
  parameter int WAYS   = 2,
  parameter int WORDS  = 2,
  parameter int DTAG_W = 26,
  parameter int DIDX_W = 3,
  parameter int DBLK_W = 1
) (
  input logic CLK,
  input logic RST,
  dcache_miss_controller_if.master bus
);

  // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [DBLK_W-1:0] LAST = DBLK_W'(WORDS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_COMMIT, S_DONE
`ifdef DCACHE_FLUSH_EN
    , S_FSCAN, S_FWB, S_FLUSHED
`endif
  } state_e;

  state_e              state_q;
  logic [DBLK_W-1:0]   cnt_q;
  logic [DIDX_W-1:0]   idx_q;
  logic [DTAG_W-1:0]   mtag_q;
  logic [DTAG_W-1:0]   vtag_q;
  logic                vway_q;
`ifdef DCACHE_FLUSH_EN
  logic [DIDX_W:0]     fptr_q;
  logic                fhit;
`endif

  logic                vic;
  logic                vdirty;
  logic [DTAG_W-1:0]   vtag;
  logic                acc;
  logic                last;
  logic [DIDX_W-1:0]   a_idx;
  logic [DTAG_W-1:0]   a_tag;

  assign acc   = bus.ramstate == RS_ACCESS;
  assign last  = cnt_q == LAST;
  assign a_idx = bus.miss_addr[2+DBLK_W +: DIDX_W];
  assign a_tag = bus.miss_addr[31 -: DTAG_W];

  always_comb begin
    if (!bus.way_v[0])      vic = 1'b0;
    else if (!bus.way_v[1]) vic = 1'b1;
    else                    vic = ~bus.mru;
    vdirty = bus.way_v[vic] & bus.way_dirty[vic];
    vtag   = bus.way_tag[int'(vic)*DTAG_W +: DTAG_W];
  end

`ifdef DCACHE_FLUSH_EN
  assign fhit = bus.way_v[fptr_q[0]] & bus.way_dirty[fptr_q[0]];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mtag_q  <= '0;
      vtag_q  <= '0;
      vway_q  <= 1'b0;
`ifdef DCACHE_FLUSH_EN
      fptr_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.miss) begin
            mtag_q  <= a_tag;
            idx_q   <= a_idx;
            vway_q  <= vic;
            vtag_q  <= vtag;
            cnt_q   <= '0;
            state_q <= vdirty ? S_WB : S_FILL;
          end
`ifdef DCACHE_FLUSH_EN
          else if (bus.flush) begin
            fptr_q  <= '0;
            state_q <= S_FSCAN;
          end
`endif
        end
        S_WB: if (acc) begin
          if (last) begin
            cnt_q   <= '0;
            state_q <= S_FILL;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_FILL: if (acc) begin
          if (last) begin
            cnt_q   <= '0;
            state_q <= S_COMMIT;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_COMMIT: state_q <= S_DONE;
        S_DONE:   state_q <= S_IDLE;
`ifdef DCACHE_FLUSH_EN
        S_FSCAN: begin
          if (fhit) begin
            idx_q   <= fptr_q[DIDX_W:1];
            vway_q  <= fptr_q[0];
            vtag_q  <= bus.way_tag[int'(fptr_q[0])*DTAG_W +: DTAG_W];
            cnt_q   <= '0;
            state_q <= S_FWB;
          end else if (&fptr_q) state_q <= S_FLUSHED;
          else fptr_q <= fptr_q + 1'b1;
        end
        S_FWB: if (acc) begin
          if (last) begin
            cnt_q <= '0;
            if (&fptr_q) state_q <= S_FLUSHED;
            else begin
              fptr_q  <= fptr_q + 1'b1;
              state_q <= S_FSCAN;
            end
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_FLUSHED: state_q <= S_FLUSHED;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.arr_idx     = '0;
    bus.arr_way     = 1'b0;
    bus.arr_word    = '0;
    bus.fill_we     = 1'b0;
    bus.fill_data   = '0;
    bus.fill_commit = 1'b0;
    bus.clean_we    = 1'b0;
    bus.mem_ren     = 1'b0;
    bus.mem_wen     = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_store   = '0;
    bus.miss_done   = 1'b0;
    bus.flushed     = 1'b0;
    bus.busy        = state_q != S_IDLE;
    unique case (state_q)
      S_IDLE: bus.arr_idx = a_idx;
`ifdef DCACHE_FLUSH_EN
      S_WB, S_FWB: begin
        bus.clean_we = (state_q == S_FWB) & acc & last;
`else
      S_WB: begin
`endif
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = {vtag_q, idx_q, cnt_q, 2'b00};
        bus.mem_store = bus.victim_word;
        bus.arr_idx   = idx_q;
        bus.arr_way   = vway_q;
        bus.arr_word  = cnt_q;
      end
      S_FILL: begin
        bus.mem_ren   = 1'b1;
        bus.mem_addr  = {mtag_q, idx_q, cnt_q, 2'b00};
        bus.arr_idx   = idx_q;
        bus.arr_way   = vway_q;
        bus.arr_word  = cnt_q;
        bus.fill_we   = acc;
        bus.fill_data = acc ? bus.mem_load : '0;
      end
      S_COMMIT: begin
        bus.fill_commit = 1'b1;
        bus.arr_idx     = idx_q;
        bus.arr_way     = vway_q;
      end
      S_DONE: begin
        bus.miss_done = 1'b1;
        bus.arr_idx   = idx_q;
        bus.arr_way   = vway_q;
      end
`ifdef DCACHE_FLUSH_EN
      S_FSCAN: begin
        bus.arr_idx = fptr_q[DIDX_W:1];
        bus.arr_way = fptr_q[0];
      end
      S_FLUSHED: bus.flushed = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Directed bench for dcache_miss_controller; flush steps follow DCACHE_FLUSH_EN.
module tb_dcache_miss_controller;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dcache_miss_controller_if bus ();

  dcache_miss_controller dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  int total = 0;
  int bad   = 0;

  logic        fm;
  logic [1:0]  tv, td;
  logic [51:0] tt;

  always_comb begin
    bus.way_v     = fm ? 2'b11 : tv;
    bus.way_dirty = fm ? ((bus.arr_idx == 3'd0 || bus.arr_idx == 3'd5)
                          ? 2'b10 : 2'b00) : td;
    bus.way_tag   = fm ? {26'h0AB + 26'(bus.arr_idx), 26'h0CD} : tt;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) if (RST === 1'b0) begin
    total++;
    assert (!(bus.mem_ren && bus.mem_wen)) else begin
      bad++;
      $error("FAIL ren_wen_excl observed=%b%b expected=not 11",
             bus.mem_ren, bus.mem_wen);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    fm = 1'b0; tv = '0; td = '0; tt = '0;
    bus.miss = 1'b0; bus.miss_addr = '0; bus.mru = 1'b0;
    bus.victim_word = '0; bus.mem_load = '0;
    bus.ramstate = 2'd0; bus.flush = 1'b0;
    repeat (2) cyc();
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst ren", bus.mem_ren, 0);
    chk("rst wen", bus.mem_wen, 0);
    chk("rst addr", bus.mem_addr, 0);
    chk("rst store", bus.mem_store, 0);
    chk("rst fill_we", bus.fill_we, 0);
    chk("rst commit", bus.fill_commit, 0);
    chk("rst done", bus.miss_done, 0);
    chk("rst idx", bus.arr_idx, 0);
    chk("rst way", bus.arr_way, 0);
    chk("rst word", bus.arr_word, 0);
    chk("rst flushed", bus.flushed, 0);
    chk("rst clean", bus.clean_we, 0);
    RST = 1'b0;

    // clean miss, empty set
    cyc(); bus.miss = 1; bus.miss_addr = 32'h0000_1048; tv = 2'b00;
    bus.ramstate = 2'd2; bus.mem_load = 32'hD0D0_0000; #1;
    chk("t1 idle idx", bus.arr_idx, 1);
    chk("t1 idle busy", bus.busy, 0);
    cyc(); #1;
    chk("t1 f0 ren", bus.mem_ren, 1);
    chk("t1 f0 wen", bus.mem_wen, 0);
    chk("t1 f0 addr", bus.mem_addr, 32'h1048);
    chk("t1 f0 we", bus.fill_we, 1);
    chk("t1 f0 data", bus.fill_data, 32'hD0D0_0000);
    chk("t1 f0 way", bus.arr_way, 0);
    chk("t1 f0 word", bus.arr_word, 0);
    cyc(); bus.mem_load = 32'hD0D0_0001; #1;
    chk("t1 f1 addr", bus.mem_addr, 32'h104C);
    chk("t1 f1 data", bus.fill_data, 32'hD0D0_0001);
    chk("t1 f1 word", bus.arr_word, 1);
    chk("t1 f1 we", bus.fill_we, 1);
    cyc(); #1;
    chk("t1 commit", bus.fill_commit, 1);
    chk("t1 c done", bus.miss_done, 0);
    chk("t1 c idx", bus.arr_idx, 1);
    chk("t1 c ren", bus.mem_ren, 0);
    cyc(); #1;
    chk("t1 done", bus.miss_done, 1);
    chk("t1 d commit", bus.fill_commit, 0);
    cyc(); bus.miss = 0; #1;
    chk("t1 end done", bus.miss_done, 0);
    chk("t1 end busy", bus.busy, 0);

    // dirty victim in way 1
    cyc(); bus.miss = 1; bus.miss_addr = 32'h0000_AA90;
    tv = 2'b11; td = 2'b10; tt = {26'h155, 26'h0AA}; bus.mru = 0;
    bus.victim_word = 32'hCAFE_0000; #1;
    chk("t2 idle idx", bus.arr_idx, 2);
    cyc(); tv = 0; tt = '0; bus.mru = 1;
    bus.miss_addr = 32'hFFFF_FFFF; #1;
    chk("t2 wb0 wen", bus.mem_wen, 1);
    chk("t2 wb0 ren", bus.mem_ren, 0);
    chk("t2 wb0 addr", bus.mem_addr, 32'h5550);
    chk("t2 wb0 store", bus.mem_store, 32'hCAFE_0000);
    chk("t2 wb0 way", bus.arr_way, 1);
    chk("t2 wb0 word", bus.arr_word, 0);
    chk("t2 wb0 idx", bus.arr_idx, 2);
    chk("t2 wb0 fill_we", bus.fill_we, 0);
    cyc(); bus.victim_word = 32'hCAFE_0001; #1;
    chk("t2 wb1 addr", bus.mem_addr, 32'h5554);
    chk("t2 wb1 store", bus.mem_store, 32'hCAFE_0001);
    chk("t2 wb1 word", bus.arr_word, 1);
    cyc(); bus.mem_load = 32'hBEEF_0000; #1;
    chk("t2 f0 ren", bus.mem_ren, 1);
    chk("t2 f0 addr", bus.mem_addr, 32'hAA90);
    chk("t2 f0 we", bus.fill_we, 1);
    chk("t2 f0 way", bus.arr_way, 1);
    chk("t2 f0 data", bus.fill_data, 32'hBEEF_0000);
    cyc(); #1;
    chk("t2 f1 addr", bus.mem_addr, 32'hAA94);
    cyc(); #1;
    chk("t2 commit", bus.fill_commit, 1);
    chk("t2 c way", bus.arr_way, 1);
    cyc(); #1;
    chk("t2 done", bus.miss_done, 1);
    cyc(); bus.miss = 0; bus.miss_addr = '0; #1;
    chk("t2 end busy", bus.busy, 0);

    // stall then error then access on fill word 0
    cyc(); bus.miss = 1; bus.miss_addr = 32'h0000_3008; tv = 0; td = 0;
    bus.ramstate = 2'd2; #1;
    cyc(); bus.ramstate = 2'd1; #1;
    chk("t3 busy0 ren", bus.mem_ren, 1);
    chk("t3 busy0 addr", bus.mem_addr, 32'h3008);
    chk("t3 busy0 we", bus.fill_we, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("t3 busy ren", bus.mem_ren, 1);
      chk("t3 busy addr", bus.mem_addr, 32'h3008);
      chk("t3 busy we", bus.fill_we, 0);
      chk("t3 busy done", bus.miss_done, 0);
    end
    cyc(); bus.ramstate = 2'd3; #1;
    chk("t3 err addr", bus.mem_addr, 32'h3008);
    chk("t3 err ren", bus.mem_ren, 1);
    chk("t3 err we", bus.fill_we, 0);
    chk("t3 err word", bus.arr_word, 0);
    cyc(); bus.ramstate = 2'd2; bus.mem_load = 32'h0000_1234; #1;
    chk("t3 acc we", bus.fill_we, 1);
    chk("t3 acc addr", bus.mem_addr, 32'h3008);
    chk("t3 acc word", bus.arr_word, 0);
    cyc(); #1;
    chk("t3 f1 addr", bus.mem_addr, 32'h300C);
    chk("t3 f1 we", bus.fill_we, 1);
    cyc(); #1;
    chk("t3 commit", bus.fill_commit, 1);
    chk("t3 c done", bus.miss_done, 0);
    cyc(); #1;
    chk("t3 done", bus.miss_done, 1);
    cyc(); bus.miss = 0; #1;
    chk("t3 end busy", bus.busy, 0);

    // reset during write-back
    cyc(); bus.miss = 1; bus.miss_addr = 32'h0000_AA90;
    tv = 2'b11; td = 2'b10; tt = {26'h155, 26'h0AA}; bus.mru = 0; #1;
    cyc(); #1;
    chk("t4 wb0 wen", bus.mem_wen, 1);
    cyc(); RST = 1; bus.miss = 0; bus.miss_addr = '0;
    bus.ramstate = 2'd0; #1;
    chk("t4 wb1 addr", bus.mem_addr, 32'h5554);
    cyc(); #1;
    chk("t4 rst busy", bus.busy, 0);
    chk("t4 rst wen", bus.mem_wen, 0);
    chk("t4 rst ren", bus.mem_ren, 0);
    chk("t4 rst addr", bus.mem_addr, 0);
    chk("t4 rst store", bus.mem_store, 0);
    chk("t4 rst way", bus.arr_way, 0);
    chk("t4 rst word", bus.arr_word, 0);
    chk("t4 rst idx", bus.arr_idx, 0);
    chk("t4 rst we", bus.fill_we, 0);
    RST = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("t4 post commit", bus.fill_commit, 0);
      chk("t4 post done", bus.miss_done, 0);
      chk("t4 post busy", bus.busy, 0);
    end

    // back-to-back misses
    cyc(); bus.miss = 1; bus.miss_addr = 32'h0000_7F38; tv = 0; td = 0;
    bus.ramstate = 2'd2; #1;
    chk("t5a idle idx", bus.arr_idx, 7);
    cyc(); #1;
    chk("t5a f0 addr", bus.mem_addr, 32'h7F38);
    cyc(); #1;
    chk("t5a f1 addr", bus.mem_addr, 32'h7F3C);
    cyc(); #1;
    chk("t5a commit", bus.fill_commit, 1);
    cyc(); #1;
    chk("t5a done", bus.miss_done, 1);
    cyc(); bus.miss_addr = 32'h0001_2360; #1;
    chk("t5b idle busy", bus.busy, 0);
    chk("t5b idle idx", bus.arr_idx, 4);
    cyc(); #1;
    chk("t5b f0 ren", bus.mem_ren, 1);
    chk("t5b f0 addr", bus.mem_addr, 32'h0001_2360);
    chk("t5b f0 idx", bus.arr_idx, 4);
    cyc(); #1;
    chk("t5b f1 addr", bus.mem_addr, 32'h0001_2364);
    cyc(); #1;
    chk("t5b commit", bus.fill_commit, 1);
    chk("t5b c idx", bus.arr_idx, 4);
    cyc(); #1;
    chk("t5b done", bus.miss_done, 1);
    cyc(); bus.miss = 0; #1;
    chk("t5b end busy", bus.busy, 0);

`ifdef DCACHE_FLUSH_EN
    begin
      int wr, cl, rd;
      logic [31:0] fa, la;
      wr = 0; cl = 0; rd = 0; fa = '0; la = '0;
      cyc(); fm = 1; bus.flush = 1; bus.ramstate = 2'd2; #1;
      for (int i = 0; i < 200; i++) begin
        cyc(); #1;
        if (bus.flushed) break;
        if (bus.mem_wen) begin
          wr++;
          if (wr == 1) fa = bus.mem_addr;
          la = bus.mem_addr;
        end
        if (bus.clean_we) cl++;
        if (bus.mem_ren) rd++;
      end
      chk("fl flushed", bus.flushed, 1);
      chk("fl writes", wr, 4);
      chk("fl cleans", cl, 2);
      chk("fl reads", rd, 0);
      chk("fl first addr", fa, 32'h2AC0);
      chk("fl last addr", la, 32'h2C2C);
      bus.flush = 0; bus.miss = 1; bus.miss_addr = 32'h0000_1048;
      for (int i = 0; i < 3; i++) begin
        cyc(); #1;
        chk("fl hold", bus.flushed, 1);
        chk("fl miss ign", bus.mem_ren, 0);
      end
      bus.miss = 0; fm = 0;
    end
`else
    cyc(); bus.flush = 1; #1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("nofl busy", bus.busy, 0);
      chk("nofl flushed", bus.flushed, 0);
      chk("nofl clean", bus.clean_we, 0);
    end
    bus.flush = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
